ex_lane_coordinator_t: RTL and testbench
========================================

// Module: ex_lane_coordinator_t
// PURPOSE
// - N-lane successor of the dual-issue EX coordination unit; sits between EX lanes and ME/fetch.
// - Orders lanes by wrapping order tag; flags store->load same-word hazards; propagates stalls to younger lanes.
// - Selects the oldest taken branch as a registered one-cycle redirect and masks younger lanes.
// - Blanks stale redirects for a programmable window after each redirect.
// PARAMETERS
// LANES      2   number of EX lanes (2..4)
// ORDER_W    2   order-tag width; tags wrap modulo 2^ORDER_W
// ADDR_W     30  word-address width compared for hazards (alu[31:2])
// PC_W       32  branch target width
// BLANK_CYC  2   cycles after a redirect during which new pcsrc is ignored (0 = none)
// PORTS
// CLK           in   1               clock, rising edge
// RST           in   1               asynchronous reset, active-low
// ACT           in   1               stage enable; 0 = all registers hold
// lane_valid    in   LANES           lane holds a valid instruction
// lane_order    in   LANES*ORDER_W   per-lane program-order tag
// lane_memop    in   LANES*4         memop; 0 none, 1..3 store, other nonzero load
// lane_addr     in   LANES*ADDR_W    effective word address
// lane_pcsrc    in   LANES           lane resolves a taken branch/jump
// lane_bradd    in   LANES*PC_W      lane branch target
// me_stall      in   LANES           per-lane stall from ME
// stall_q       out  LANES           registered per-lane stall
// sthaz_q       out  LANES           registered store-hazard flag
// kill_q        out  LANES           registered: lane younger than the redirecting branch
// redirect_q    out  1               one-cycle redirect pulse
// redirect_pc_q out  PC_W            redirect target, valid with redirect_q
// oldest_q      out  clog2(LANES)    index of oldest valid lane
// BEHAVIOUR
// - All outputs registered; latency 1 cycle from inputs. Reset (RST=0): every output 0, blank counter 0.
// - ACT=0: outputs and blank counter hold; a pending blank window does not count down.
// - Age: i older than j iff both valid and (order_j-order_i) mod 2^ORDER_W in [1, 2^(ORDER_W-1)).
//   Invalid lanes are younger than every valid lane. Equal tags: lower index is older.
// - sthaz[j] = valid[j] & memop[j]!=0 & some older i with store memop[i] and addr[i]==addr[j].
// - base[i] = sthaz[i] | me_stall[i]; stall[j] = base[j] | base[i] for any i older than j.
// - Taken set T = lanes with valid & pcsrc & !stall. If T nonempty and blank counter == 0:
//   redirect_q=1, redirect_pc_q = bradd of oldest lane in T, kill_q = lanes younger than it,
//   blank counter loads BLANK_CYC. Otherwise redirect_q=0, kill_q=0, redirect_pc_q holds.
// - Blank counter decrements by 1 per ACT cycle while nonzero; pcsrc ignored while nonzero.
// - Stalled branch neither redirects nor blanks; it redirects on the first unstalled cycle.
// - oldest_q: oldest valid lane; 0 if no lane valid.
// - Simultaneous: redirect and stall on distinct lanes allowed; a killed lane still reports its stall.
// - Reset mid-window clears the counter; the first post-reset taken branch redirects.
// CONFIGURATION
// - EX_COORD_PERF_EN defined: add outputs perf_redirect_cnt, perf_sthaz_cnt (32 bits each).
//   Each increments once per ACT cycle with redirect / any sthaz; wraps at 2^32; reset to 0.
// - EX_COORD_PERF_EN undefined: counters and ports absent; all other behaviour identical.
// TESTING
// - Reset: RST low mid-traffic -> all outputs 0 during reset and on the first cycle after release.
// - LANES=2, lane0 store order=3, lane1 load order=0 (wrapped), equal addr ->
//   sthaz_q=2'b10, stall_q=2'b10.
// - LANES=4, lanes 1 and 3 taken, lane3 older -> redirect_q=1, pc=bradd3, kill_q = younger lanes.
// - BLANK_CYC=2: redirect, then pcsrc for 2 cycles -> redirect_q 0,0; on 3rd cycle -> 1.
// - me_stall on the oldest lane -> stall_q all valid lanes; taken branch on a younger lane suppressed.
// - ACT=0 for 3 cycles inside blank window -> counter holds; window resumes when ACT returns to 1.

Source files
------------

// File: rtl/ex_lane_coordinator_t.sv
// N-lane EX coordinator: lane age ordering, store->load hazards, stall propagation, oldest-branch redirect with blanking.
// Optional EX_COORD_PERF_EN adds 32-bit redirect / store-hazard event counters.
module ex_lane_coordinator_t #(
  parameter int LANES     = 2,
  parameter int ORDER_W   = 2,
  parameter int ADDR_W    = 30,
  parameter int PC_W      = 32,
  parameter int BLANK_CYC = 2,
  localparam int IDX_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       act,
  input  logic [LANES-1:0]           lane_valid,
  input  logic [LANES*ORDER_W-1:0]   lane_order,
  input  logic [LANES*4-1:0]         lane_memop,
  input  logic [LANES*ADDR_W-1:0]    lane_addr,
  input  logic [LANES-1:0]           lane_pcsrc,
  input  logic [LANES*PC_W-1:0]      lane_bradd,
  input  logic [LANES-1:0]           me_stall,
  output logic [LANES-1:0]           stall_q,
  output logic [LANES-1:0]           sthaz_q,
  output logic [LANES-1:0]           kill_q,
  output logic                       redirect_q,
  output logic [PC_W-1:0]            redirect_pc_q,
  output logic [IDX_W-1:0]           oldest_q
`ifdef EX_COORD_PERF_EN
  ,
  output logic [31:0]                perf_redirect_cnt,
  output logic [31:0]                perf_sthaz_cnt
`endif
);

  localparam int BW   = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam int HALF = 1 << (ORDER_W - 1);

  logic [ORDER_W-1:0] ord   [LANES];
  logic [3:0]         mop   [LANES];
  logic [ADDR_W-1:0]  addr  [LANES];
  logic [PC_W-1:0]    bradd [LANES];
  // older[i][j]: lane i is older than lane j
  logic [LANES-1:0]   older [LANES];
  logic [ORDER_W-1:0] tag_diff;

  logic [LANES-1:0]   sthaz_c;
  logic [LANES-1:0]   base_c;
  logic [LANES-1:0]   stall_c;
  logic [LANES-1:0]   taken_c;
  logic [LANES-1:0]   kill_c;
  logic [PC_W-1:0]    sel_pc;
  logic               sel_found;
  logic               sel_beaten;
  logic [IDX_W-1:0]   oldest_c;
  logic               old_found;
  logic               old_beaten;
  logic               fire;
  logic [BW-1:0]      blank_cnt;

  function automatic logic is_store(input logic [3:0] m);
    return (m != 4'd0) && (m[3:2] == 2'b00);
  endfunction

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      ord[i]   = lane_order[i*ORDER_W +: ORDER_W];
      mop[i]   = lane_memop[i*4 +: 4];
      addr[i]  = lane_addr[i*ADDR_W +: ADDR_W];
      bradd[i] = lane_bradd[i*PC_W +: PC_W];
    end
  end

  // Invalid lanes sort behind every valid lane; equal tags fall back to lane index.
  always_comb begin
    tag_diff = '0;
    for (int i = 0; i < LANES; i++) older[i] = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (i != j && lane_valid[i]) begin
          if (!lane_valid[j]) begin
            older[i][j] = 1'b1;
          end else begin
            tag_diff    = ord[j] - ord[i];
            older[i][j] = ((tag_diff != '0) && (int'(tag_diff) < HALF)) ||
                          ((tag_diff == '0) && (i < j));
          end
        end
      end
    end
  end

  always_comb begin
    sthaz_c = '0;
    stall_c = '0;
    for (int j = 0; j < LANES; j++) begin
      if (lane_valid[j] && mop[j] != 4'd0) begin
        for (int i = 0; i < LANES; i++) begin
          if (older[i][j] && is_store(mop[i]) && addr[i] == addr[j]) sthaz_c[j] = 1'b1;
        end
      end
    end
    base_c = sthaz_c | me_stall;
    for (int j = 0; j < LANES; j++) begin
      stall_c[j] = base_c[j];
      for (int i = 0; i < LANES; i++) begin
        if (older[i][j] && base_c[i]) stall_c[j] = 1'b1;
      end
    end
  end

  always_comb begin
    taken_c    = lane_valid & lane_pcsrc & ~stall_c;
    sel_found  = 1'b0;
    sel_beaten = 1'b0;
    sel_pc     = '0;
    kill_c     = '0;
    old_found  = 1'b0;
    old_beaten = 1'b0;
    oldest_c   = '0;
    for (int i = 0; i < LANES; i++) begin
      sel_beaten = 1'b0;
      old_beaten = 1'b0;
      for (int k = 0; k < LANES; k++) begin
        if (taken_c[k] && older[k][i]) sel_beaten = 1'b1;
        if (lane_valid[k] && older[k][i]) old_beaten = 1'b1;
      end
      if (taken_c[i] && !sel_beaten && !sel_found) begin
        sel_found = 1'b1;
        sel_pc    = bradd[i];
        kill_c    = older[i];
      end
      if (lane_valid[i] && !old_beaten && !old_found) begin
        old_found = 1'b1;
        oldest_c  = IDX_W'(i);
      end
    end
  end

  assign fire = sel_found && (blank_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q       <= '0;
      sthaz_q       <= '0;
      kill_q        <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      oldest_q      <= '0;
      blank_cnt     <= '0;
    end else if (act) begin
      stall_q  <= stall_c;
      sthaz_q  <= sthaz_c;
      oldest_q <= oldest_c;
      if (fire) begin
        redirect_q    <= 1'b1;
        redirect_pc_q <= sel_pc;
        kill_q        <= kill_c;
        blank_cnt     <= BW'(BLANK_CYC);
      end else begin
        redirect_q <= 1'b0;
        kill_q     <= '0;
        if (blank_cnt != '0) blank_cnt <= blank_cnt - 1'b1;
      end
    end
  end

`ifdef EX_COORD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_redirect_cnt <= '0;
      perf_sthaz_cnt    <= '0;
    end else if (act) begin
      if (fire)     perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      if (|sthaz_c) perf_sthaz_cnt    <= perf_sthaz_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_lane_coordinator_t.sv
// Scoreboard bench for ex_lane_coordinator_t: a 4-lane instance (ORDER_W=3) and a 2-lane instance (ORDER_W=2).
module tb_ex_lane_coordinator_t;

  logic clk;
  logic rst_n;
  logic act;

  logic [3:0]   v4, pcs4, ms4;
  logic [11:0]  ord4;
  logic [15:0]  mem4;
  logic [119:0] addr4;
  logic [127:0] br4;
  logic [3:0]   stall4, sthaz4, kill4;
  logic         red4;
  logic [31:0]  pc4;
  logic [1:0]   old4;

  logic [1:0]   v2, pcs2, ms2;
  logic [3:0]   ord2;
  logic [7:0]   mem2;
  logic [59:0]  addr2;
  logic [63:0]  br2;
  logic [1:0]   stall2, sthaz2, kill2;
  logic         red2;
  logic [31:0]  pc2;
  logic         old2;

`ifdef EX_COORD_PERF_EN
  logic [31:0] pr4, ps4, pr2, ps2;
`endif

  ex_lane_coordinator_t #(.LANES(4), .ORDER_W(3), .ADDR_W(30), .PC_W(32), .BLANK_CYC(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .act(act),
    .lane_valid(v4), .lane_order(ord4), .lane_memop(mem4), .lane_addr(addr4),
    .lane_pcsrc(pcs4), .lane_bradd(br4), .me_stall(ms4),
    .stall_q(stall4), .sthaz_q(sthaz4), .kill_q(kill4), .redirect_q(red4),
    .redirect_pc_q(pc4), .oldest_q(old4)
`ifdef EX_COORD_PERF_EN
    , .perf_redirect_cnt(pr4), .perf_sthaz_cnt(ps4)
`endif
  );

  ex_lane_coordinator_t #(.LANES(2), .ORDER_W(2), .ADDR_W(30), .PC_W(32), .BLANK_CYC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .act(act),
    .lane_valid(v2), .lane_order(ord2), .lane_memop(mem2), .lane_addr(addr2),
    .lane_pcsrc(pcs2), .lane_bradd(br2), .me_stall(ms2),
    .stall_q(stall2), .sthaz_q(sthaz2), .kill_q(kill2), .redirect_q(red2),
    .redirect_pc_q(pc2), .oldest_q(old2)
`ifdef EX_COORD_PERF_EN
    , .perf_redirect_cnt(pr2), .perf_sthaz_cnt(ps2)
`endif
  );

  typedef struct {
    logic [3:0]  stall, sthaz, kill;
    logic        red;
    logic [31:0] pc;
    logic [1:0]  old;
    bit          c2;
    logic [1:0]  stall2, sthaz2, kill2;
    logic        red2;
    logic        old2;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  bit         p2_en = 0;
  logic [1:0] p2_stall, p2_sthaz, p2_kill;
  logic       p2_red, p2_old;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_assert++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  task automatic idle();
    v4 = '0; pcs4 = '0; ms4 = '0; ord4 = '0; mem4 = '0; addr4 = '0; br4 = '0;
    v2 = '0; pcs2 = '0; ms2 = '0; ord2 = '0; mem2 = '0; addr2 = '0; br2 = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic lane4(input int l, input logic [2:0] o, input logic [3:0] m, input logic [29:0] a,
                       input logic p, input logic [31:0] b, input logic s);
    v4[l] = 1'b1; ord4[l*3 +: 3] = o; mem4[l*4 +: 4] = m; addr4[l*30 +: 30] = a;
    pcs4[l] = p; br4[l*32 +: 32] = b; ms4[l] = s;
  endtask

  task automatic lane2(input int l, input logic [1:0] o, input logic [3:0] m, input logic [29:0] a);
    v2[l] = 1'b1; ord2[l*2 +: 2] = o; mem2[l*4 +: 4] = m; addr2[l*30 +: 30] = a;
  endtask

  // All four lanes valid with tags 5,6,7,0 (lane3 wraps, youngest).
  task automatic orders_a();
    lane4(0, 3'd5, 4'd0, 30'h0, 1'b0, 32'h0, 1'b0);
    lane4(1, 3'd6, 4'd0, 30'h0, 1'b0, 32'h0, 1'b0);
    lane4(2, 3'd7, 4'd0, 30'h0, 1'b0, 32'h0, 1'b0);
    lane4(3, 3'd0, 4'd0, 30'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic exp2(input logic [1:0] st, input logic [1:0] sh, input logic [1:0] kl,
                      input logic rd, input logic od);
    p2_en = 1; p2_stall = st; p2_sthaz = sh; p2_kill = kl; p2_red = rd; p2_old = od;
  endtask

  task automatic expect_out(input logic [3:0] st, input logic [3:0] sh, input logic [3:0] kl,
                            input logic rd, input logic [31:0] pc, input logic [1:0] od);
    exp_t e;
    e.stall = st; e.sthaz = sh; e.kill = kl; e.red = rd; e.pc = pc; e.old = od;
    e.c2 = p2_en; e.stall2 = p2_stall; e.sthaz2 = p2_sthaz; e.kill2 = p2_kill;
    e.red2 = p2_red; e.old2 = p2_old;
    q.push_back(e);
    p2_en = 0;
  endtask

  // Monitor: each vector is driven at a falling edge and its response is visible just after the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_q",       stall4, e.stall);
        chk("sthaz_q",       sthaz4, e.sthaz);
        chk("kill_q",        kill4,  e.kill);
        chk("redirect_q",    red4,   e.red);
        chk("redirect_pc_q", pc4,    e.pc);
        chk("oldest_q",      old4,   e.old);
        if (e.c2) begin
          chk("l2_stall_q",    stall2, e.stall2);
          chk("l2_sthaz_q",    sthaz2, e.sthaz2);
          chk("l2_kill_q",     kill2,  e.kill2);
          chk("l2_redirect_q", red2,   e.red2);
          chk("l2_oldest_q",   old2,   e.old2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, queue depth %0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    act   = 1'b1;
    idle();

    // reset held, then released with idle inputs
    cyc(); exp2(2'b00, 2'b00, 2'b00, 1'b0, 1'b0); expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h0, 2'd0);
    cyc(); expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h0, 2'd0);
    cyc(); rst_n = 1'b1;
    exp2(2'b00, 2'b00, 2'b00, 1'b0, 1'b0); expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h0, 2'd0);

    // oldest by tag; 2-lane wrapped store(3)->load(0) same word
    cyc();
    lane4(0, 3'd2, 4'd0, 30'h0, 1'b0, 32'h0, 1'b0);
    lane4(1, 3'd1, 4'd0, 30'h0, 1'b0, 32'h0, 1'b0);
    lane4(2, 3'd0, 4'd0, 30'h0, 1'b0, 32'h0, 1'b0);
    lane2(0, 2'd3, 4'd1, 30'h55);
    lane2(1, 2'd0, 4'd5, 30'h55);
    exp2(2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
    expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h0, 2'd2);

    // 4-lane hazard: lane1 load hits lane0 store; younger store on lane3 does not flag lane2
    cyc();
    lane4(0, 3'd0, 4'd1, 30'h100, 1'b0, 32'h0, 1'b0);
    lane4(1, 3'd1, 4'd4, 30'h100, 1'b0, 32'h0, 1'b0);
    lane4(2, 3'd2, 4'd4, 30'h104, 1'b0, 32'h0, 1'b0);
    lane4(3, 3'd3, 4'd2, 30'h104, 1'b0, 32'h0, 1'b0);
    lane2(0, 2'd3, 4'd1, 30'h55);
    lane2(1, 2'd0, 4'd5, 30'h56);
    exp2(2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    expect_out(4'b1110, 4'b0010, 4'h0, 1'b0, 32'h0, 2'd0);

    // me_stall on oldest lane stalls all and suppresses a younger taken branch
    cyc(); orders_a(); ms4[0] = 1'b1; pcs4[2] = 1'b1; br4[2*32 +: 32] = 32'h2000;
    lane2(0, 2'd0, 4'd1, 30'h55);
    lane2(1, 2'd3, 4'd5, 30'h55);
    exp2(2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    expect_out(4'b1111, 4'h0, 4'h0, 1'b0, 32'h0, 2'd0);

    // stall released: branch fires, wrapped lane3 is younger and killed
    cyc(); orders_a(); pcs4[2] = 1'b1; br4[2*32 +: 32] = 32'h2000;
    expect_out(4'h0, 4'h0, 4'b1000, 1'b1, 32'h2000, 2'd0);

    // blank window, first cycle
    cyc(); orders_a(); pcs4[0] = 1'b1; br4[31:0] = 32'h3000;
    expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h2000, 2'd0);

    // act low for 3 cycles: everything holds despite new stall and branch inputs
    for (int k = 0; k < 3; k++) begin
      cyc(); act = 1'b0; orders_a(); ms4[0] = 1'b1; pcs4[0] = 1'b1; br4[31:0] = 32'h3000;
      expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h2000, 2'd0);
    end

    // window resumes: one blanked cycle left, then redirect
    cyc(); act = 1'b1; orders_a(); pcs4[0] = 1'b1; br4[31:0] = 32'h3000;
    expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h2000, 2'd0);
    cyc(); orders_a(); pcs4[0] = 1'b1; br4[31:0] = 32'h3000;
    expect_out(4'h0, 4'h0, 4'b1110, 1'b1, 32'h3000, 2'd0);

    // plain blanking: 0, 0, then 1
    for (int k = 0; k < 3; k++) begin
      cyc(); orders_a(); pcs4[1] = 1'b1; br4[1*32 +: 32] = 32'h4000;
      if (k < 2) expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h3000, 2'd0);
      else       expect_out(4'h0, 4'h0, 4'b1100, 1'b1, 32'h4000, 2'd0);
    end

    // let the window expire
    cyc(); expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h4000, 2'd0);
    cyc(); expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h4000, 2'd0);

    // lanes 1 and 3 taken, lane3 oldest
    cyc();
    lane4(0, 3'd2, 4'd0, 30'h0, 1'b0, 32'h0,    1'b0);
    lane4(1, 3'd3, 4'd0, 30'h0, 1'b1, 32'h5000, 1'b0);
    lane4(2, 3'd4, 4'd0, 30'h0, 1'b0, 32'h0,    1'b0);
    lane4(3, 3'd1, 4'd0, 30'h0, 1'b1, 32'h6000, 1'b0);
    expect_out(4'h0, 4'h0, 4'b0111, 1'b1, 32'h6000, 2'd3);

    // reset mid-window with traffic present
    for (int k = 0; k < 2; k++) begin
      cyc(); rst_n = 1'b0;
      lane4(1, 3'd3, 4'd0, 30'h0, 1'b1, 32'h5000, 1'b0);
      lane4(3, 3'd1, 4'd0, 30'h0, 1'b1, 32'h6000, 1'b0);
      expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h0, 2'd0);
    end
    cyc(); rst_n = 1'b1;
    expect_out(4'h0, 4'h0, 4'h0, 1'b0, 32'h0, 2'd0);

    // first post-reset branch redirects; the next one is blanked
    for (int k = 0; k < 2; k++) begin
      cyc();
      lane4(0, 3'd1, 4'd0, 30'h0, 1'b0, 32'h0,    1'b0);
      lane4(1, 3'd0, 4'd0, 30'h0, 1'b1, 32'h7000, 1'b0);
      lane4(2, 3'd2, 4'd0, 30'h0, 1'b0, 32'h0,    1'b0);
      lane4(3, 3'd3, 4'd0, 30'h0, 1'b0, 32'h0,    1'b0);
      if (k == 0) expect_out(4'h0, 4'h0, 4'b1101, 1'b1, 32'h7000, 2'd1);
      else        expect_out(4'h0, 4'h0, 4'h0,    1'b0, 32'h7000, 2'd1);
    end

    cyc();
    for (int k = 0; k < 5 && q.size() != 0; k++) @(posedge clk);
    #2;
    chk("scoreboard_drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
